pattern_gen_ps: RTL and testbench

Parametrised, synthesizable word-pattern generator that feeds the parallel-to-serial converter. Emits a WIDTH-bit data word plus a one-cycle load strobe every PERIOD clocks, with selectable pattern mode (incrementing, PRBS, walking-one, constant), a run/stop handshake, an optional word-count limit and a saturate-or-wrap rule for the counter mode. Sits between the test/control logic and the serializer's parallel input.

---
 rtl/pattern_gen_ps.sv | 187 ++++++++++++++++++
 tb/tb_pattern_gen_ps.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_gen_ps.sv
// Word-pattern generator feeding a parallel-to-serial converter: one WIDTH-bit word plus a
// load strobe every PERIOD clocks. Optional LFSR mode is compiled in with PATGEN_PRBS_EN.
module pattern_gen_ps #(
    parameter int               WIDTH  = 10,
    parameter int               PERIOD = 11,
    parameter logic [WIDTH-1:0] TAPS   = 10'b1001000000,
    parameter int               CW     = 16
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] SEED,
    input  logic             SAT,
    input  logic [CW-1:0]    COUNT_LIMIT,
    output logic [WIDTH-1:0] D,
    output logic             LOADS,
    output logic             IS,
    output logic             DONE,
    output logic [CW-1:0]    WCNT
);

    localparam int               PHW      = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [PHW-1:0]   PH_LAST  = PHW'(PERIOD - 1);
    localparam logic [PHW-1:0]   PH_ONE   = PHW'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] W_ONE    = WIDTH'(1);
    localparam logic [CW-1:0]    CW_ONE   = CW'(1);

    localparam logic [1:0] MODE_INC  = 2'b00;
    localparam logic [1:0] MODE_PRBS = 2'b01;
    localparam logic [1:0] MODE_WALK = 2'b10;

    generate
        if (WIDTH < 2 || PERIOD < 2 || PERIOD > 1024 || TAPS[WIDTH-1] == 1'b0) begin : g_bad_cfg
            $error("pattern_gen_ps: illegal parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // First word of a run; an all-zero seed would lock up the LFSR and the walking one.
    function automatic logic [WIDTH-1:0] first_word(input logic [1:0]       mode,
                                                    input logic [WIDTH-1:0] seed);
        logic [WIDTH-1:0] w;
        w = seed;
        case (mode)
`ifdef PATGEN_PRBS_EN
            MODE_PRBS: begin
                if (seed == {WIDTH{1'b0}}) w = ALL_ONES;
                else                       w = seed;
            end
`endif
            MODE_WALK: begin
                if (seed == {WIDTH{1'b0}}) w = W_ONE;
                else                       w = seed;
            end
            default: w = seed;
        endcase
        return w;
    endfunction

    function automatic logic [WIDTH-1:0] next_word(input logic [WIDTH-1:0] d,
                                                   input logic [1:0]       mode,
                                                   input logic             sat);
        logic [WIDTH-1:0] n;
        n = d;
        case (mode)
            MODE_INC: begin
                if (sat && d == ALL_ONES) n = d;
                else                      n = d + W_ONE;
            end
`ifdef PATGEN_PRBS_EN
            MODE_PRBS: n = {d[WIDTH-2:0], ^(d & TAPS)};
`endif
            MODE_WALK: n = {d[WIDTH-2:0], d[WIDTH-1]};
            default:   n = d;
        endcase
        return n;
    endfunction

    state_t           r_state;
    logic [PHW-1:0]   r_ph;
    logic [1:0]       r_mode;
    logic             r_sat;
    logic [CW-1:0]    r_limit;
    logic [WIDTH-1:0] r_d;
    logic             r_loads;
    logic             r_is;
    logic             r_done;
    logic [CW-1:0]    r_wcnt;

    logic             w_word_end;
    logic             w_limit_hit;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_first;

    // Word-boundary decisions and next data word, from the latched run configuration.
    always_comb begin
        w_word_end  = (r_ph == PH_LAST);
        w_limit_hit = (r_limit != {CW{1'b0}}) && (r_wcnt == r_limit);
        w_next      = next_word(r_d, r_mode, r_sat);
        w_first     = first_word(MODE, SEED);
    end

    // Run-control FSM; every output is a register updated here.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_ph    <= {PHW{1'b0}};
            r_mode  <= 2'b00;
            r_sat   <= 1'b0;
            r_limit <= {CW{1'b0}};
            r_d     <= {WIDTH{1'b0}};
            r_loads <= 1'b0;
            r_is    <= 1'b1;
            r_done  <= 1'b0;
            r_wcnt  <= {CW{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ENABLE) begin
                        r_state <= S_RUN;
                        r_mode  <= MODE;
                        r_sat   <= SAT;
                        r_limit <= COUNT_LIMIT;
                        r_d     <= w_first;
                        r_ph    <= {PHW{1'b0}};
                        r_loads <= 1'b1;
                        r_is    <= 1'b0;
                        r_wcnt  <= CW_ONE;
                    end else begin
                        r_loads <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!w_word_end) begin
                        r_ph    <= r_ph + PH_ONE;
                        r_loads <= 1'b0;
                    end else if (w_limit_hit) begin
                        r_state <= S_DONE;
                        r_is    <= 1'b1;
                        r_done  <= 1'b1;
                        r_loads <= 1'b0;
                    end else if (!ENABLE) begin
                        // Stop is only honoured here, so a word is never cut short.
                        r_state <= S_IDLE;
                        r_is    <= 1'b1;
                        r_loads <= 1'b0;
                    end else begin
                        r_ph    <= {PHW{1'b0}};
                        r_d     <= w_next;
                        r_loads <= 1'b1;
                        r_wcnt  <= r_wcnt + CW_ONE;
                    end
                end
                S_DONE: begin
                    r_loads <= 1'b0;
                    if (!ENABLE) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end else begin
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ph    <= {PHW{1'b0}};
                    r_loads <= 1'b0;
                    r_is    <= 1'b1;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign D     = r_d;
    assign LOADS = r_loads;
    assign IS    = r_is;
    assign DONE  = r_done;
    assign WCNT  = r_wcnt;

endmodule

// File: tb/tb_pattern_gen_ps.sv
// Directed bench for pattern_gen_ps: cycle model compared every clock plus literal word tables.
module tb_pattern_gen_ps;

    localparam int W    = 10;
    localparam int P    = 11;
    localparam int CW   = 16;
    localparam int MAXV = 1023;

    logic          CLOCK       = 1'b0;
    logic          RESET       = 1'b1;
    logic          ENABLE      = 1'b0;
    logic [1:0]    MODE        = 2'b00;
    logic [W-1:0]  SEED        = 10'd0;
    logic          SAT         = 1'b0;
    logic [CW-1:0] COUNT_LIMIT = 16'd0;
    logic [W-1:0]  D;
    logic          LOADS;
    logic          IS;
    logic          DONE;
    logic [CW-1:0] WCNT;

    pattern_gen_ps #(
        .WIDTH (W),
        .PERIOD(P),
        .TAPS  (10'b1001000000),
        .CW    (CW)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .ENABLE     (ENABLE),
        .MODE       (MODE),
        .SEED       (SEED),
        .SAT        (SAT),
        .COUNT_LIMIT(COUNT_LIMIT),
        .D          (D),
        .LOADS      (LOADS),
        .IS         (IS),
        .DONE       (DONE),
        .WCNT       (WCNT)
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Word number k of a run, computed directly from the pattern rules.
    function automatic logic [W-1:0] mword(input logic [1:0] mode, input logic [W-1:0] seed,
                                           input bit sat, input int k);
        int v;
        int f;
        int s;
        case (mode)
            2'd0: begin
                v = int'(seed) + k;
                if (sat && v > MAXV) v = MAXV;
                return W'(v % (MAXV + 1));
            end
            2'd1: begin
`ifdef PATGEN_PRBS_EN
                v = (seed == 10'd0) ? MAXV : int'(seed);
                for (int i = 0; i < k; i++)
                    v = ((v << 1) | (((v >> 9) ^ (v >> 6)) & 1)) & MAXV;
                return W'(v);
`else
                return seed;
`endif
            end
            2'd2: begin
                f = (seed == 10'd0) ? 1 : int'(seed);
                s = k % W;
                v = ((f << s) | (f >> (W - s))) & MAXV;
                return W'(v);
            end
            default: return seed;
        endcase
    endfunction

    bit            m_run   = 1'b0;
    bit            m_done  = 1'b0;
    bit            m_loads = 1'b0;
    logic [W-1:0]  m_d     = 10'd0;
    logic [CW-1:0] m_wcnt  = 16'd0;
    int            m_t     = 0;
    logic [1:0]    m_mode  = 2'b00;
    logic [W-1:0]  m_seed  = 10'd0;
    bit            m_sat   = 1'b0;
    logic [CW-1:0] m_lim   = 16'd0;

    // Reference: m_t counts cycles since the run's first strobe; word index is m_t / P.
    always @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            m_run <= 1'b0; m_done <= 1'b0; m_loads <= 1'b0;
            m_d <= 10'd0; m_wcnt <= 16'd0; m_t <= 0;
        end else if (m_run) begin
            if ((m_t % P) != P - 1) begin
                m_t <= m_t + 1; m_loads <= 1'b0;
            end else if (m_lim != 16'd0 && m_wcnt == m_lim) begin
                m_run <= 1'b0; m_done <= 1'b1; m_loads <= 1'b0;
            end else if (!ENABLE) begin
                m_run <= 1'b0; m_loads <= 1'b0;
            end else begin
                m_t <= m_t + 1;
                m_d <= mword(m_mode, m_seed, m_sat, (m_t + 1) / P);
                m_loads <= 1'b1;
                m_wcnt <= m_wcnt + 16'd1;
            end
        end else if (m_done) begin
            m_loads <= 1'b0;
            if (!ENABLE) m_done <= 1'b0;
        end else begin
            m_loads <= 1'b0;
            if (ENABLE) begin
                m_run <= 1'b1; m_t <= 0; m_loads <= 1'b1; m_wcnt <= 16'd1;
                m_mode <= MODE; m_seed <= SEED; m_sat <= SAT; m_lim <= COUNT_LIMIT;
                m_d <= mword(MODE, SEED, SAT, 0);
            end
        end
    end

    always @(negedge CLOCK) begin
        if (!RESET) begin
            check("cyc_D", 32'(D), 32'(m_d));
            check("cyc_LOADS", 32'(LOADS), 32'(m_loads));
            check("cyc_IS", 32'(IS), 32'(!m_run));
            check("cyc_DONE", 32'(DONE), 32'(m_done));
            check("cyc_WCNT", 32'(WCNT), 32'(m_wcnt));
        end
    end

    logic [31:0] cap_d[$];
    logic [31:0] cap_w[$];

    task automatic start_run(input logic [1:0] mode, input logic [W-1:0] seed,
                             input logic sat, input logic [CW-1:0] lim);
        @(negedge CLOCK);
        MODE = mode; SEED = seed; SAT = sat; COUNT_LIMIT = lim; ENABLE = 1'b1;
    endtask

    task automatic capture(input int n);
        int got;
        int c;
        got = 0;
        c = 0;
        cap_d.delete();
        cap_w.delete();
        while (c < (n + 2) * P && got < n) begin
            @(negedge CLOCK);
            if (LOADS) begin
                cap_d.push_back(32'(D));
                cap_w.push_back(32'(WCNT));
                got++;
            end
            c++;
        end
        check("capture_count", 32'(got), 32'(n));
    endtask

    task automatic stop_run();
        int c;
        @(negedge CLOCK);
        ENABLE = 1'b0;
        c = 0;
        while (c < 3 * P && !(IS && !DONE)) begin
            @(negedge CLOCK);
            c++;
        end
        check("stop_idle", {30'd0, IS, DONE}, 32'd2);
        @(negedge CLOCK);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_a[];
        int zeros;
        int early;
        int c;
        int nl;

        repeat (2) @(negedge CLOCK);
        check("rst_D", 32'(D), 32'd0);
        check("rst_LOADS", 32'(LOADS), 32'd0);
        check("rst_IS", 32'(IS), 32'd1);
        check("rst_DONE", 32'(DONE), 32'd0);
        check("rst_WCNT", 32'(WCNT), 32'd0);
        #2 RESET = 1'b0;

        start_run(2'b00, 10'd0, 1'b1, 16'd0);
        capture(4);
        exp_a = '{0, 1, 2, 3};
        foreach (exp_a[i]) check("inc_from0", cap_d[i], 32'(exp_a[i]));
        stop_run();

        start_run(2'b00, 10'd1021, 1'b1, 16'd0);
        capture(5);
        exp_a = '{1021, 1022, 1023, 1023, 1023};
        foreach (exp_a[i]) check("inc_sat", cap_d[i], 32'(exp_a[i]));
        stop_run();

        start_run(2'b00, 10'd1022, 1'b0, 16'd0);
        capture(4);
        exp_a = '{1022, 1023, 0, 1};
        foreach (exp_a[i]) check("inc_wrap", cap_d[i], 32'(exp_a[i]));
        foreach (exp_a[i]) check("inc_wrap_wcnt", cap_w[i], 32'(i + 1));
        stop_run();

        start_run(2'b01, 10'd0, 1'b0, 16'd0);
`ifdef PATGEN_PRBS_EN
        capture(1024);
        exp_a = '{'h3FF, 'h3FE, 'h3FC};
        foreach (exp_a[i]) check("prbs_head", cap_d[i], 32'(exp_a[i]));
        zeros = 0;
        early = 0;
        for (int k = 1; k < 1023; k++) begin
            if (cap_d[k] == 32'd0) zeros++;
            if (cap_d[k] == cap_d[0]) early++;
        end
        check("prbs_zero_words", 32'(zeros), 32'd0);
        check("prbs_early_repeat", 32'(early), 32'd0);
        check("prbs_period", cap_d[1023], 32'h3FF);
`else
        capture(3);
        exp_a = '{0, 0, 0};
        foreach (exp_a[i]) check("prbs_off_const", cap_d[i], 32'(exp_a[i]));
`endif
        stop_run();

        start_run(2'b10, 10'd0, 1'b0, 16'd12);
        capture(12);
        exp_a = '{1, 2, 4, 8, 16, 32, 64, 128, 256, 512, 1, 2};
        foreach (exp_a[i]) check("walk_limit", cap_d[i], 32'(exp_a[i]));
        nl = 0;
        repeat (3 * P) begin
            @(negedge CLOCK);
            if (LOADS) nl++;
        end
        check("done_no_loads", 32'(nl), 32'd0);
        check("done_flags", {30'd0, IS, DONE}, 32'd3);
        @(negedge CLOCK);
        ENABLE = 1'b0;
        @(negedge CLOCK);
        check("done_clear", {30'd0, IS, DONE}, 32'd2);
        repeat (3) @(negedge CLOCK);
        check("idle_no_loads", 32'(LOADS), 32'd0);
        ENABLE = 1'b1;
        @(negedge CLOCK);
        check("restart_loads", 32'(LOADS), 32'd1);
        check("restart_D", 32'(D), 32'd1);
        check("restart_WCNT", 32'(WCNT), 32'd1);
        stop_run();

        start_run(2'b11, 10'h155, 1'b0, 16'd0);
        capture(1);
        repeat (3) @(negedge CLOCK);
        ENABLE = 1'b0;
        c = 0;
        nl = 0;
        while (c < 20 && !IS) begin
            @(negedge CLOCK);
            if (LOADS) nl++;
            c++;
        end
        check("drop_latency", 32'(c), 32'd8);
        check("drop_no_loads", 32'(nl), 32'd0);
        @(negedge CLOCK);
        ENABLE = 1'b1;
        @(negedge CLOCK);
        check("reen_LOADS", 32'(LOADS), 32'd1);
        check("reen_D", 32'(D), 32'h155);
        check("reen_WCNT", 32'(WCNT), 32'd1);
        stop_run();

        start_run(2'b00, 10'd0, 1'b0, 16'd0);
        capture(4);
        check("pre_reset_D", cap_d[3], 32'd3);
        repeat (5) @(negedge CLOCK);
        #1;
        RESET = 1'b1;
        ENABLE = 1'b0;
        #1;
        check("async_rst_D", 32'(D), 32'd0);
        check("async_rst_LOADS", 32'(LOADS), 32'd0);
        check("async_rst_IS", 32'(IS), 32'd1);
        check("async_rst_WCNT", 32'(WCNT), 32'd0);
        check("async_rst_DONE", 32'(DONE), 32'd0);
        @(negedge CLOCK);
        #2 RESET = 1'b0;
        repeat (4) @(negedge CLOCK);
        check("post_rst_idle", {30'd0, IS, LOADS}, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
